// File: rtl/ibex_instr_bus_responder.sv
// ibex_instr_bus_responder
//
// Behavioural instruction-memory responder for the Ibex fetch interface.
// Grants fetch requests combinationally, looks the word up in a backing
// array during the grant cycle, and returns every response in grant order
// exactly ReadLatency cycles after its grant edge. Addresses at or beyond
// the array size respond with an error and zero data. A separate load port
// fills the array; array contents survive reset.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   instr_req_i     fetch request
//   instr_addr_i    fetch byte address (bits [1:0] ignored)
//   instr_gnt_o     request accepted this cycle
//   instr_rvalid_o  response valid this cycle
//   instr_rdata_o   response word (zero when not valid or on error)
//   instr_err_o     response error (zero when not valid)
//   gnt_stall_i     forces instr_gnt_o low while high
//   mem_we_i        load port write enable
//   mem_waddr_i     load port byte address (word aligned)
//   mem_wdata_i     load port write data

module ibex_instr_bus_responder #(
  parameter int unsigned MemWords       = 1024,
  parameter int unsigned ReadLatency    = 1,
  parameter int unsigned NumOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        gnt_stall_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_waddr_i,
  input  logic [31:0] mem_wdata_i
);

  localparam int unsigned AW = $clog2(MemWords);
  localparam int unsigned PW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam logic [2:0]    CNT_INIT  = 3'(ReadLatency - 1);
  localparam logic [2:0]    MAX_OUT   = 3'(NumOutstanding);
  localparam logic [PW-1:0] LAST_SLOT = PW'(NumOutstanding - 1);

  // Backing array; never reset.
  logic [31:0] mem [MemWords];

  // Response queue: one slot per outstanding request, each with its own
  // latency countdown. Because grants are at most one per cycle and every
  // slot uses the same latency, the slot at rd_ptr always matures first.
  logic        slot_valid [NumOutstanding];
  logic [2:0]  slot_cnt   [NumOutstanding];
  logic [31:0] slot_data  [NumOutstanding];
  logic        slot_err   [NumOutstanding];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [2:0]    outstanding_q;

  logic          gnt;
  logic          rvalid;
  logic          req_oor;
  logic          wr_oor;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] wr_idx;
  logic          unused_addr_bits;

  assign req_idx = instr_addr_i[AW+1:2];
  assign wr_idx  = mem_waddr_i[AW+1:2];
  assign req_oor = instr_addr_i[31:2] >= 30'(MemWords);
  assign wr_oor  = mem_waddr_i[31:2]  >= 30'(MemWords);

  // Byte-offset bits carry no meaning on either port.
  assign unused_addr_bits = ^{instr_addr_i[1:0], mem_waddr_i[1:0]};

  assign gnt    = instr_req_i & ~gnt_stall_i & (outstanding_q < MAX_OUT);
  assign rvalid = slot_valid[rd_ptr] && (slot_cnt[rd_ptr] == 3'd0);

  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = rvalid;
  assign instr_rdata_o  = rvalid ? slot_data[rd_ptr] : 32'h0;
  assign instr_err_o    = rvalid ? slot_err[rd_ptr]  : 1'b0;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_SLOT) ? '0 : ptr + 1'b1;
  endfunction

  // Load port. Out-of-range writes are simply not performed.
  always_ff @(posedge clk_i) begin
    if (mem_we_i && !wr_oor) begin
      mem[wr_idx] <= mem_wdata_i;
    end
  end

  // Queue and outstanding count. The array read happens in the grant cycle
  // and the non-blocking load-port write lands at the same edge, so a
  // same-word collision returns the pre-write contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= 3'd0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      for (int i = 0; i < NumOutstanding; i++) begin
        slot_valid[i] <= 1'b0;
        slot_cnt[i]   <= 3'd0;
        slot_data[i]  <= 32'h0;
        slot_err[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NumOutstanding; i++) begin
        if (slot_valid[i] && (slot_cnt[i] != 3'd0)) begin
          slot_cnt[i] <= slot_cnt[i] - 3'd1;
        end
      end

      if (rvalid) begin
        slot_valid[rd_ptr] <= 1'b0;
        rd_ptr             <= next_ptr(rd_ptr);
      end

      // The grant can never target the slot being retired: a grant needs
      // a free slot, and a full queue blocks grants until after the pop.
      if (gnt) begin
        slot_valid[wr_ptr] <= 1'b1;
        slot_cnt[wr_ptr]   <= CNT_INIT;
        slot_data[wr_ptr]  <= req_oor ? 32'h0 : mem[req_idx];
        slot_err[wr_ptr]   <= req_oor;
        wr_ptr             <= next_ptr(wr_ptr);
      end

      case ({gnt, rvalid})
        2'b10:   outstanding_q <= outstanding_q + 3'd1;
        2'b01:   outstanding_q <= outstanding_q - 3'd1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_instr_bus_responder.sv
// Directed testbench for ibex_instr_bus_responder. Two instances share all
// stimulus: dut_a uses the default single-cycle latency, dut_b uses
// ReadLatency=3. Inputs change 1 time unit after the rising edge and outputs
// are sampled 3 units later.

module tb_ibex_instr_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        stall;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  logic        a_gnt, a_rv, a_err;
  logic [31:0] a_rdata;
  logic        b_gnt, b_rv, b_err;
  logic [31:0] b_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ibex_instr_bus_responder #(
    .MemWords(1024), .ReadLatency(1), .NumOutstanding(2)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(a_gnt), .instr_rvalid_o(a_rv),
    .instr_rdata_o(a_rdata), .instr_err_o(a_err),
    .gnt_stall_i(stall),
    .mem_we_i(we), .mem_waddr_i(waddr), .mem_wdata_i(wdata)
  );

  ibex_instr_bus_responder #(
    .MemWords(1024), .ReadLatency(3), .NumOutstanding(2)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(b_gnt), .instr_rvalid_o(b_rv),
    .instr_rdata_o(b_rdata), .instr_err_o(b_err),
    .gnt_stall_i(stall),
    .mem_we_i(we), .mem_waddr_i(waddr), .mem_wdata_i(wdata)
  );

  // Stimulus/expectation table for the outstanding-limit scenario.
  localparam bit        SEQ_REQ  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam bit [31:0] SEQ_ADDR [8] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h0, 32'h0, 32'h0};
  // dut_b: NumOutstanding=2, ReadLatency=3
  localparam bit        B_GNT  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam bit        B_RV   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam bit [31:0] B_DATA [8] = '{32'h0, 32'h0, 32'h0, 32'h13, 32'h11111111,
                                       32'h0, 32'h0, 32'h22222222};
  // dut_a: ReadLatency=1, never fills, so grants and rvalids run back to back
  localparam bit        A_GNT  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam bit        A_RV   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam bit [31:0] A_DATA [8] = '{32'h0, 32'h13, 32'h11111111, 32'h22222222,
                                       32'h22222222, 32'h22222222, 32'h0, 32'h0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic apply_reset();
    req = 1'b0; stall = 1'b0; we = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = 1'b0; stall = 1'b0; we = 1'b0;
    rst_n = 1'b0;
    tick();
    settle();
    checks++;
    if ({a_gnt, a_rv, a_err, b_gnt, b_rv, b_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 000000", {a_gnt, a_rv, a_err, b_gnt, b_rv, b_err});
    end
    checks++;
    if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata: got %h/%h required 0", a_rdata, b_rdata);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    apply_reset();
    req = 1'b1; addr = 32'h0;
    settle();
    checks++;
    if (a_gnt !== 1'b1 || a_rv !== 1'b0) begin
      failures++;
      $display("FAIL basic_gnt: gnt=%b rv=%b required gnt=1 rv=0", a_gnt, a_rv);
    end
    tick();
    req = 1'b0; addr = 32'h123;
    settle();
    $display("basic: rv=%b rdata=%h err=%b", a_rv, a_rdata, a_err);
    checks++;
    if (a_rv !== 1'b1 || a_rdata !== 32'h13 || a_err !== 1'b0) begin
      failures++;
      $display("FAIL basic_resp: rv=%b rdata=%h err=%b required 1/00000013/0", a_rv, a_rdata, a_err);
    end
    tick();
    settle();
    checks++;
    if (a_rv !== 1'b0 || a_rdata !== 32'h0) begin
      failures++;
      $display("FAIL basic_single: rv=%b rdata=%h required 0/0", a_rv, a_rdata);
    end
  endtask

  // Runs the shared table: dut_b exercises the outstanding limit,
  // dut_a the back-to-back grant/response path.
  task automatic test_back_to_back();
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      req  = SEQ_REQ[c];
      addr = SEQ_ADDR[c];
      settle();
      $display("cyc %0d: b gnt=%b rv=%b rdata=%h | a gnt=%b rv=%b rdata=%h",
               c, b_gnt, b_rv, b_rdata, a_gnt, a_rv, a_rdata);
      checks++;
      if (b_gnt !== B_GNT[c] || b_rv !== B_RV[c] || b_rdata !== B_DATA[c] || b_err !== 1'b0) begin
        failures++;
        $display("FAIL outstanding_c%0d: gnt=%b rv=%b rdata=%h err=%b required %b/%b/%h/0",
                 c, b_gnt, b_rv, b_rdata, b_err, B_GNT[c], B_RV[c], B_DATA[c]);
      end
      checks++;
      if (a_gnt !== A_GNT[c] || a_rv !== A_RV[c] || a_rdata !== A_DATA[c] || a_err !== 1'b0) begin
        failures++;
        $display("FAIL b2b_c%0d: gnt=%b rv=%b rdata=%h err=%b required %b/%b/%h/0",
                 c, a_gnt, a_rv, a_rdata, a_err, A_GNT[c], A_RV[c], A_DATA[c]);
      end
      tick();
    end
  endtask

  task automatic test_range();
    apply_reset();
    load(32'h00001000, 32'h00000055);  // out of range, must not alias word 0
    req = 1'b1; addr = 32'h00001000;
    settle();
    checks++;
    if (a_gnt !== 1'b1) begin
      failures++;
      $display("FAIL range_gnt: got %b required 1", a_gnt);
    end
    tick();
    addr = 32'h00000FFC;
    settle();
    $display("range 0x1000: rv=%b rdata=%h err=%b", a_rv, a_rdata, a_err);
    checks++;
    if (a_rv !== 1'b1 || a_err !== 1'b1 || a_rdata !== 32'h0) begin
      failures++;
      $display("FAIL range_err: rv=%b err=%b rdata=%h required 1/1/00000000", a_rv, a_err, a_rdata);
    end
    tick();
    addr = 32'h0;
    settle();
    $display("range 0xFFC: rv=%b rdata=%h err=%b", a_rv, a_rdata, a_err);
    checks++;
    if (a_rv !== 1'b1 || a_err !== 1'b0 || a_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL range_top: rv=%b err=%b rdata=%h required 1/0/deadbeef", a_rv, a_err, a_rdata);
    end
    tick();
    req = 1'b0;
    settle();
    checks++;
    if (a_rv !== 1'b1 || a_err !== 1'b0 || a_rdata !== 32'h13) begin
      failures++;
      $display("FAIL range_drop: rv=%b err=%b rdata=%h required 1/0/00000013", a_rv, a_err, a_rdata);
    end
    tick();
  endtask

  task automatic test_stall();
    apply_reset();
    stall = 1'b1; req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      addr = (c == 0) ? 32'h10 : 32'h20;
      settle();
      checks++;
      if (a_gnt !== 1'b0 || a_rv !== 1'b0) begin
        failures++;
        $display("FAIL stall_c%0d: gnt=%b rv=%b required 0/0", c, a_gnt, a_rv);
      end
      tick();
    end
    stall = 1'b0;
    settle();
    checks++;
    if (a_gnt !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: gnt=%b required 1", a_gnt);
    end
    tick();
    req = 1'b0;
    settle();
    $display("stall: rv=%b rdata=%h", a_rv, a_rdata);
    checks++;
    if (a_rv !== 1'b1 || a_rdata !== 32'h0000B0B0) begin
      failures++;
      $display("FAIL stall_data: rv=%b rdata=%h required 1/0000b0b0", a_rv, a_rdata);
    end
    tick();
  endtask

  task automatic test_read_before_write();
    apply_reset();
    we = 1'b1; waddr = 32'h8; wdata = 32'hAAAA5555;
    req = 1'b1; addr = 32'h8;
    settle();
    checks++;
    if (a_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rbw_gnt: gnt=%b required 1", a_gnt);
    end
    tick();
    we = 1'b0;
    settle();
    $display("rbw old: rv=%b rdata=%h", a_rv, a_rdata);
    checks++;
    if (a_rv !== 1'b1 || a_rdata !== 32'h22222222) begin
      failures++;
      $display("FAIL rbw_old: rv=%b rdata=%h required 1/22222222", a_rv, a_rdata);
    end
    tick();
    req = 1'b0;
    settle();
    $display("rbw new: rv=%b rdata=%h", a_rv, a_rdata);
    checks++;
    if (a_rv !== 1'b1 || a_rdata !== 32'hAAAA5555) begin
      failures++;
      $display("FAIL rbw_new: rv=%b rdata=%h required 1/aaaa5555", a_rv, a_rdata);
    end
    tick();
  endtask

  task automatic test_reset_flush();
    apply_reset();
    req = 1'b1; addr = 32'h0;
    tick();
    addr = 32'h4;
    settle();
    checks++;
    if (b_gnt !== 1'b1) begin
      failures++;
      $display("FAIL flush_fill: gnt=%b required 1", b_gnt);
    end
    tick();
    req = 1'b0;
    rst_n = 1'b0;
    settle();
    checks++;
    if (b_rv !== 1'b0 || b_rdata !== 32'h0 || b_err !== 1'b0) begin
      failures++;
      $display("FAIL flush_in_reset: rv=%b rdata=%h err=%b required 0/0/0", b_rv, b_rdata, b_err);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle();
      checks++;
      if (b_rv !== 1'b0) begin
        failures++;
        $display("FAIL flush_quiet_c%0d: rv=%b required 0", c, b_rv);
      end
      tick();
    end
    req = 1'b1; addr = 32'h4;
    settle();
    checks++;
    if (b_gnt !== 1'b1) begin
      failures++;
      $display("FAIL flush_regrant1: gnt=%b required 1", b_gnt);
    end
    tick();
    addr = 32'h8;
    settle();
    checks++;
    if (b_gnt !== 1'b1) begin
      failures++;
      $display("FAIL flush_regrant2: gnt=%b required 1", b_gnt);
    end
    tick();
    req = 1'b0;
    settle();
    checks++;
    if (b_rv !== 1'b0) begin
      failures++;
      $display("FAIL flush_early: rv=%b required 0", b_rv);
    end
    tick();
    settle();
    $display("flush resp1: rv=%b rdata=%h", b_rv, b_rdata);
    checks++;
    if (b_rv !== 1'b1 || b_rdata !== 32'h11111111) begin
      failures++;
      $display("FAIL flush_resp1: rv=%b rdata=%h required 1/11111111", b_rv, b_rdata);
    end
    tick();
    settle();
    $display("flush resp2: rv=%b rdata=%h", b_rv, b_rdata);
    checks++;
    if (b_rv !== 1'b1 || b_rdata !== 32'hAAAA5555) begin
      failures++;
      $display("FAIL flush_resp2: rv=%b rdata=%h required 1/aaaa5555", b_rv, b_rdata);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; addr = 32'h0; stall = 1'b0;
    we = 1'b0; waddr = 32'h0; wdata = 32'h0;
    tick();
    load(32'h0,   32'h00000013);
    load(32'h4,   32'h11111111);
    load(32'h8,   32'h22222222);
    load(32'h10,  32'h0000A0A0);
    load(32'h20,  32'h0000B0B0);
    load(32'hFFC, 32'hDEADBEEF);
    test_reset();
    test_basic();
    test_back_to_back();
    test_range();
    test_stall();
    test_read_before_write();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
